// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: issues one memory read per accepted start, writes the
// returned word into the IR, and handshakes with decode. Handles misaligned PCs, timeouts and flushes.
module fetch_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Start,
    input  logic [31:0] i_Pc,
    input  logic        i_Flush,
    input  logic        i_InstrAck,
    input  logic        i_FaultClr,
    output logic        o_MemRd,
    output logic [31:0] o_MemAddr,
    input  logic [31:0] i_MemData,
    input  logic        i_MemValid,
    output logic        o_IrWr,
    output logic [31:0] o_IrData,
    output logic        o_InstrValid,
    output logic        o_Busy,
    output logic        o_Fault,
    output logic        o_FaultCause,
    output logic [31:0] o_FaultAddr,
    output logic [15:0] o_FetchCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_FAULT
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  timer_q, timer_d;
    logic [15:0] fetch_count_q, fetch_count_d;
    logic        fault_cause_q, fault_cause_d;
    logic        mem_rd_q, instr_valid_q, busy_q, fault_q;
    logic        ir_wr;
    logic        timer_expired;

    // A flush in WAIT can push the timer one past the last value, so DRAIN uses >=.
    assign timer_expired = (timer_q >= TIMER_LAST);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        timer_d       = timer_q;
        fetch_count_d = fetch_count_q;
        fault_cause_d = fault_cause_q;
        ir_wr         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!i_Flush && i_Start) begin
                    addr_d = i_Pc;
                    if (i_Pc[1:0] != 2'b00) begin
                        state_d       = S_FAULT;
                        fault_cause_d = 1'b0;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                timer_d = '0;
                state_d = i_Flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (i_Flush) begin
                    // A response coinciding with the flush is already drained.
                    state_d = i_MemValid ? S_IDLE : S_DRAIN;
                    timer_d = timer_q + 8'd1;
                end else if (i_MemValid) begin
                    ir_wr         = 1'b1;
                    fetch_count_d = fetch_count_q + 16'd1;
                    state_d       = S_HOLD;
                end else if (timer_expired) begin
                    state_d       = S_FAULT;
                    fault_cause_d = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (i_Flush || i_InstrAck) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (i_MemValid || timer_expired) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_FAULT: begin
                if (i_FaultClr) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            timer_q       <= '0;
            fetch_count_q <= '0;
            fault_cause_q <= 1'b0;
            mem_rd_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            timer_q       <= timer_d;
            fetch_count_q <= fetch_count_d;
            fault_cause_q <= fault_cause_d;
            mem_rd_q      <= (state_d == S_REQ);
            instr_valid_q <= (state_d == S_HOLD);
            busy_q        <= (state_d != S_IDLE);
            fault_q       <= (state_d == S_FAULT);
        end
    end

    assign o_MemRd      = mem_rd_q;
    assign o_MemAddr    = addr_q;
    assign o_FaultAddr  = addr_q;
    assign o_IrWr       = ir_wr;
    assign o_IrData     = ir_wr ? i_MemData : '0;
    assign o_InstrValid = instr_valid_q;
    assign o_Busy       = busy_q;
    assign o_Fault      = fault_q;
    assign o_FaultCause = fault_cause_q;
    assign o_FetchCount = fetch_count_q;

endmodule
